// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-port signals around the IF/MEM port arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              mem_stall;

  logic              port_valid;
  logic              port_we;
  logic [ADDR_W-1:0] port_addr;
  logic [DATA_W-1:0] port_wdata;
  logic              port_ready;
  logic [DATA_W-1:0] port_rdata;

  logic              busy;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, port_ready, port_rdata,
    output if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_stall,
    output port_valid, port_we, port_addr, port_wdata, busy
  );

  // Pipeline and memory side.
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, port_ready, port_rdata,
    input  if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_stall,
    input  port_valid, port_we, port_addr, port_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and the MEM stage.
// MEM has priority, but IF is forced through after MAX_STREAK back-to-back MEM grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STREAK = 3
) (
  input logic              clock,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_STREAK);

  typedef enum logic [1:0] {StIdle, StGntIf, StGntMem, StDone} state_e;

  state_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                port_valid_q, port_valid_d;
  logic                port_we_q, port_we_d;
  logic [ADDR_W-1:0]   port_addr_q, port_addr_d;
  logic [DATA_W-1:0]   port_wdata_q, port_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
  logic                if_done_q, if_done_d;
  logic                mem_done_q, mem_done_d;
  logic                grant_if, grant_mem;

  // Next-state, port registers, completion capture and starvation counter.
  always_comb begin
    state_d      = state_q;
    port_valid_d = port_valid_q;
    port_we_d    = port_we_q;
    port_addr_d  = port_addr_q;
    port_wdata_d = port_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    if_done_d    = 1'b0;
    mem_done_d   = 1'b0;
    grant_if     = 1'b0;
    grant_mem    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.if_req && (!bus.mem_req || streak_q == STREAK_LIMIT)) begin
          grant_if     = 1'b1;
          state_d      = StGntIf;
          port_valid_d = 1'b1;
          port_we_d    = 1'b0;
          port_addr_d  = bus.if_addr;
          port_wdata_d = '0;
        end else if (bus.mem_req) begin
          grant_mem    = 1'b1;
          state_d      = StGntMem;
          port_valid_d = 1'b1;
          port_we_d    = bus.mem_we;
          port_addr_d  = bus.mem_addr;
          port_wdata_d = bus.mem_wdata;
        end
      end
      StGntIf: begin
        if (bus.port_ready) begin
          if_rdata_d   = bus.port_rdata;
          if_done_d    = 1'b1;
          port_valid_d = 1'b0;
          state_d      = StDone;
        end
      end
      StGntMem: begin
        if (bus.port_ready) begin
          // Stores leave the last load data visible to the pipeline.
          if (!port_we_q) begin
            mem_rdata_d = bus.port_rdata;
          end
          mem_done_d   = 1'b1;
          port_valid_d = 1'b0;
          port_we_d    = 1'b0;
          state_d      = StDone;
        end
      end
      StDone: begin
        // Requesters still see their old req here; never re-grant it.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Only MEM grants that actually overtook a waiting fetch count toward the streak.
    if (!bus.if_req || grant_if) begin
      streak_d = '0;
    end else if (grant_mem) begin
      streak_d = streak_q + STREAK_W'(1);
    end else begin
      streak_d = streak_q;
    end
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      streak_q     <= '0;
      port_valid_q <= 1'b0;
      port_we_q    <= 1'b0;
      port_addr_q  <= '0;
      port_wdata_q <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_done_q    <= 1'b0;
      mem_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      port_valid_q <= port_valid_d;
      port_we_q    <= port_we_d;
      port_addr_q  <= port_addr_d;
      port_wdata_q <= port_wdata_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_done_q    <= if_done_d;
      mem_done_q   <= mem_done_d;
    end
  end

  assign bus.port_valid = port_valid_q;
  assign bus.port_we    = port_we_q;
  assign bus.port_addr  = port_addr_q;
  assign bus.port_wdata = port_wdata_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.if_done    = if_done_q;
  assign bus.mem_done   = mem_done_q;
  assign bus.if_stall   = bus.if_req & ~if_done_q;
  assign bus.mem_stall  = bus.mem_req & ~mem_done_q;
  assign bus.busy       = (state_q != StIdle);
endmodule
